alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_unit.sv | 97 +++++++++
 rtl/alu_seq.sv | 103 ++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and defaults.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_OPW   = 4;

  localparam logic [31:0] OP_ADD   = 32'd0;
  localparam logic [31:0] OP_SUB   = 32'd1;
  localparam logic [31:0] OP_AND   = 32'd2;
  localparam logic [31:0] OP_OR    = 32'd3;
  localparam logic [31:0] OP_XOR   = 32'd4;
  localparam logic [31:0] OP_SLT   = 32'd5;
  localparam logic [31:0] OP_SLTU  = 32'd6;
  localparam logic [31:0] OP_MUL   = 32'd7;
  localparam logic [31:0] OP_MULH  = 32'd8;
  localparam logic [31:0] OP_MULHU = 32'd9;
  localparam logic [31:0] OP_DIV   = 32'd10;
  localparam logic [31:0] OP_DIVU  = 32'd11;
  localparam logic [31:0] OP_REM   = 32'd12;
  localparam logic [31:0] OP_REMU  = 32'd13;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  function automatic logic is_iter_op(input logic [31:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one double-width accumulator, one bit per cycle, WIDTH cycles.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   opd, a_in, b_in, quo, rem;
  logic [WIDTH:0]     sum, trial;
  logic [CW-1:0]      cnt;
  logic [31:0]        op_w;
  logic               busy, is_div, take_hi, negate;
  logic               signed_op, start_neg;

  assign op_w = 32'(op);

  // Signed ops run on magnitudes; the sign is restored on the way out.
  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    signed_op = (op_w == OP_MULH) || (op_w == OP_DIV) || (op_w == OP_REM);
    a_in      = (signed_op && a[WIDTH-1]) ? -a : a;
    b_in      = (signed_op && b[WIDTH-1]) ? -b : b;
    start_neg = 1'b0;
    case (op_w)
      OP_MULH: start_neg = a[WIDTH-1] ^ b[WIDTH-1];
      OP_DIV:  start_neg = (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
      OP_REM:  start_neg = a[WIDTH-1];
      default: start_neg = 1'b0;
    endcase
  end

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opd};
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    if (is_div)
      acc_nx = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nx = {sum, acc[WIDTH-1:1]};
  end

  // Result is taken from the final step so it can be registered on the done edge.
  always_comb begin
    quo  = acc_nx[WIDTH-1:0];
    rem  = acc_nx[2*WIDTH-1:WIDTH];
    prod = negate ? -acc_nx : acc_nx;
    if (is_div)
      result = take_hi ? (negate ? -rem : rem) : (negate ? -quo : quo);
    else
      result = take_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opd     <= '0;
      is_div  <= 1'b0;
      take_hi <= 1'b0;
      negate  <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      acc     <= {{WIDTH{1'b0}}, a_in};
      opd     <= b_in;
      is_div  <= (op_w >= OP_DIV) && (op_w <= OP_REMU);
      take_hi <= (op_w == OP_MULH) || (op_w == OP_MULHU) ||
                 (op_w == OP_REM)  || (op_w == OP_REMU);
      negate  <= start_neg;
    end else if (busy) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish at accept, mul/div go through the
// iterative unit; valid/ready handshake on both sides.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [OPW-1:0]   ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             lt,
  output logic             ltu,
  output logic             bge
);

  state_e           state;
  logic [31:0]      op;
  logic [WIDTH-1:0] fast_result, iter_result;
  logic             accept, iter_op, signed_lt, unsigned_lt, iter_done;

  assign op          = 32'(ALUControl);
  assign accept      = in_valid && in_ready;
  assign iter_op     = is_iter_op(op);
  assign signed_lt   = $signed(SrcA) < $signed(SrcB);
  assign unsigned_lt = SrcA < SrcB;

  always_comb begin
    fast_result = '0;
    case (op)
      OP_ADD:  fast_result = SrcA + SrcB;
      OP_SUB:  fast_result = SrcA - SrcB;
      OP_AND:  fast_result = SrcA & SrcB;
      OP_OR:   fast_result = SrcA | SrcB;
      OP_XOR:  fast_result = SrcA ^ SrcB;
      OP_SLT:  fast_result = {{(WIDTH-1){1'b0}}, signed_lt};
      OP_SLTU: fast_result = {{(WIDTH-1){1'b0}}, unsigned_lt};
      default: fast_result = '0;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH), .OPW(OPW)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_op),
    .op     (ALUControl),
    .a      (SrcA),
    .b      (SrcB),
    .done   (iter_done),
    .result (iter_result)
  );

  // in_ready is only high in IDLE, so DONE->IDLE costs a cycle with no accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      zero      <= 1'b0;
      lt        <= 1'b0;
      ltu       <= 1'b0;
      bge       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          zero     <= (SrcA == SrcB);
          lt       <= signed_lt;
          ltu      <= unsigned_lt;
          bge      <= !signed_lt;
          in_ready <= 1'b0;
          if (iter_op) begin
            state <= S_BUSY;
          end else begin
            ALUResult <= fast_result;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_BUSY: if (iter_done) begin
          ALUResult <= iter_result;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an expected-result queue checked on output.
module tb_alu_seq;

  localparam int W   = 32;
  localparam int OPW = 4;
  localparam int LAT_FAST = 1;
  localparam int LAT_ITER = W + 1;

  localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLT = 5, SLTU = 6;
  localparam int MUL = 7, MULH = 8, MULHU = 9, DIV = 10, DIVU = 11, REM = 12, REMU = 13;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid;
  logic [W-1:0]   SrcA = '0, SrcB = '0, ALUResult;
  logic [OPW-1:0] ALUControl = '0;
  logic           zero, lt, ltu, bge;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .bge        (bge)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation, push its expectation, then scramble the inputs.
  task automatic issue(input string tag, input int op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
    exp_t e;
    int   n = 0;
    logic slt;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    slt        = $signed(a) < $signed(b);
    e.res      = res;
    e.flags    = {a == b, slt, a < b, !slt};
    e.lat      = lat;
    e.tag      = tag;
    sb.push_back(e);
    in_valid   = 1'b1;
    ALUControl = OPW'(op);
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = OPW'($urandom);
  endtask

  // Wait for the result, compare against the queue head, optionally stall.
  task automatic collect(input int hold);
    exp_t e;
    int   n = 1;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check({e.tag, " latency"}, n, e.lat);
    check({e.tag, " result"}, ALUResult, e.res);
    check({e.tag, " flags"}, {zero, lt, ltu, bge}, e.flags);
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'b1;
      SrcA       = $urandom;
      SrcB       = $urandom;
      ALUControl = OPW'(ADD);
      @(negedge clk);
      check({e.tag, " hold result"}, ALUResult, e.res);
      check({e.tag, " hold flags"}, {zero, lt, ltu, bge}, e.flags);
      check({e.tag, " hold out_valid"}, out_valid, 1);
      check({e.tag, " hold in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    check({e.tag, " in_ready while done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({e.tag, " out_valid cleared"}, out_valid, 0);
    check({e.tag, " in_ready restored"}, in_ready, 1);
  endtask

  initial begin
    exp_t dropped;
    logic seen;

    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset ALUResult", ALUResult, 0);
    check("reset flags", {zero, lt, ltu, bge}, 4'b0000);
    rst_n = 1'b1;

    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle out_ready out_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    issue("ADD wrap", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, LAT_FAST);            collect(0);
    issue("SUB", SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, LAT_FAST);                 collect(0);
    issue("AND", AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, LAT_FAST); collect(0);
    issue("OR", OR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, LAT_FAST);   collect(0);
    issue("XOR bp", XOR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, LAT_FAST); collect(10);
    issue("SLT", SLT, 32'hFFFF_FFFE, 32'h1, 32'h1, LAT_FAST);                 collect(0);
    issue("SLTU", SLTU, 32'hFFFF_FFFE, 32'h1, 32'h0, LAT_FAST);               collect(0);
    issue("OP14", 14, 32'h1234, 32'h1234, 32'h0, LAT_FAST);                   collect(0);
    issue("OP15", 15, 32'h9, 32'h3, 32'h0, LAT_FAST);                         collect(0);

    issue("MUL", MUL, 32'd7, 32'd6, 32'd42, LAT_ITER);                        collect(0);
    issue("MUL low wrap", MUL, 32'h1_0000, 32'h1_0000, 32'h0, LAT_ITER);      collect(0);
    issue("MULH", MULH, 32'h8000_0000, 32'h2, 32'hFFFF_FFFF, LAT_ITER);       collect(0);
    issue("MULHU", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_ITER); collect(0);
    issue("DIV neg", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, LAT_ITER);     collect(0);
    issue("REM neg", REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, LAT_ITER);     collect(0);
    issue("DIVU", DIVU, 32'd100, 32'd7, 32'd14, LAT_ITER);                    collect(0);
    issue("REMU", REMU, 32'd100, 32'd7, 32'd2, LAT_ITER);                     collect(0);
    issue("DIVU by 0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_ITER);          collect(0);
    issue("REMU by 0", REMU, 32'd5, 32'd0, 32'd5, LAT_ITER);                  collect(0);
    issue("DIV by 0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, LAT_ITER);    collect(0);
    issue("REM by 0", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, LAT_ITER);    collect(0);
    issue("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_ITER); collect(0);
    issue("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_ITER);     collect(3);

    // Abort a divide partway through with reset; nothing may come out for it.
    issue("DIV abort", DIV, 32'd100, 32'd7, 32'd14, LAT_ITER);
    repeat (9) @(negedge clk);
    check("abort busy in_ready", in_ready, 0);
    check("abort busy out_valid", out_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort ALUResult", ALUResult, 0);
    check("abort flags", {zero, lt, ltu, bge}, 4'b0000);
    dropped = sb.pop_back();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no result", seen, 0);

    issue("ADD after reset", ADD, 32'd2, 32'd3, 32'd5, LAT_FAST);            collect(0);

    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
